// File: rtl/hazard_scoreboard_pkg.sv
// Package for the hazard scoreboard.
// Holds the forwarding-select encoding, the default parameter values and the
// helper that derives the register-index width from the register count.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // operand comes from the register file
    FWD_W  = 2'b01,  // operand forwarded from ResultW
    FWD_M  = 2'b10   // operand forwarded from ALUOutM
  } fwd_sel_t;

  localparam int DEF_NREGS        = 16;
  localparam int DEF_NSRC         = 3;
  localparam int DEF_LAT_W        = 3;
  localparam int DEF_MAX_INFLIGHT = 2;

  // Register-index width; never narrower than one bit.
  function automatic int calc_reg_w(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard.
// master: the pipeline (drives stage fields, receives stall/flush/forward).
// slave : the hazard scoreboard.
// Inputs : ra_d/use_d/wa3_d/regwrite_d/long_d (Decode), ra_e/wa3_e/regwrite_e/
//          memtoreg_e/long_e/lat_e (Execute), wa3_m/regwrite_m (Memory),
//          wa3_w/regwrite_w (Writeback), pc_pend, pcsrc_w, branch_taken_e.
// Outputs: forward_e, stall_f, stall_d, flush_d, flush_e, busy,
//          lwb_valid, lwb_reg.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NSRC  = DEF_NSRC,
  parameter int LAT_W = DEF_LAT_W
);
  localparam int REG_W = calc_reg_w(NREGS);

  logic [NSRC*REG_W-1:0] ra_d;
  logic [NSRC-1:0]       use_d;
  logic [REG_W-1:0]      wa3_d;
  logic                  regwrite_d;
  logic                  long_d;
  logic [NSRC*REG_W-1:0] ra_e;
  logic [REG_W-1:0]      wa3_e;
  logic                  regwrite_e;
  logic                  memtoreg_e;
  logic                  long_e;
  logic [LAT_W-1:0]      lat_e;
  logic [REG_W-1:0]      wa3_m;
  logic                  regwrite_m;
  logic [REG_W-1:0]      wa3_w;
  logic                  regwrite_w;
  logic                  pc_pend;
  logic                  pcsrc_w;
  logic                  branch_taken_e;
  logic [2*NSRC-1:0]     forward_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic [NREGS-1:0]      busy;
  logic                  lwb_valid;
  logic [REG_W-1:0]      lwb_reg;

  modport master (
    output ra_d, use_d, wa3_d, regwrite_d, long_d,
           ra_e, wa3_e, regwrite_e, memtoreg_e, long_e, lat_e,
           wa3_m, regwrite_m, wa3_w, regwrite_w,
           pc_pend, pcsrc_w, branch_taken_e,
    input  forward_e, stall_f, stall_d, flush_d, flush_e,
           busy, lwb_valid, lwb_reg
  );

  modport slave (
    input  ra_d, use_d, wa3_d, regwrite_d, long_d,
           ra_e, wa3_e, regwrite_e, memtoreg_e, long_e, lat_e,
           wa3_m, regwrite_m, wa3_w, regwrite_w,
           pc_pend, pcsrc_w, branch_taken_e,
    output forward_e, stall_f, stall_d, flush_d, flush_e,
           busy, lwb_valid, lwb_reg
  );
endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register latency down-counter of the scoreboard.
// Ports: clk, reset (sync, active-low), i_load/i_load_val (start a long op,
// wins over decrement), i_dec (count down one), o_count, o_busy (count != 0).
module sb_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [LAT_W-1:0] o_count,
  output logic             o_busy
);

  logic [LAT_W-1:0] r_count;

  // NOTE: state is updated with non-blocking assignments so every counter
  // samples the pre-edge values of its neighbours and the issue logic.
  always_ff @(posedge clk) begin
    if (!reset)      r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_dec)  r_count <= r_count - LAT_W'(1);
  end

  assign o_count = r_count;
  assign o_busy  = (r_count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit with a per-register scoreboard for variable-latency ops.
// Ports: clk, reset (sync, active-low), hif (slave side of
// hazard_scoreboard_if): forwarding selects for the execute operands,
// load-use / scoreboard stalls, control flushes and long-unit writeback.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS        = DEF_NREGS,
  parameter int NSRC         = DEF_NSRC,
  parameter int LAT_W        = DEF_LAT_W,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave hif
);

  localparam int REG_W = calc_reg_w(NREGS);
  localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);

  logic [LAT_W-1:0]  w_count [NREGS];
  logic [NREGS-1:0]  w_busy;
  logic [NREGS-1:0]  w_one;
  logic [NREGS-1:0]  w_win;
  logic [NREGS-1:0]  w_dec;
  logic [NREGS-1:0]  w_load;
  logic [LAT_W-1:0]  w_lat;
  logic              w_issue;
  logic              w_lwb_valid;
  logic [REG_W-1:0]  w_lwb_reg;
  logic [2*NSRC-1:0] w_forward;
  logic              w_ldstall;
  logic              w_sbstall;
  logic [IF_W-1:0]   r_inflight;

  assign w_issue = hif.regwrite_e & hif.long_e;
  // A zero latency would never mark the register busy; treat it as one.
  assign w_lat   = (hif.lat_e == '0) ? LAT_W'(1) : hif.lat_e;

  // Only one long-unit writeback per cycle: isolate the lowest register at
  // count 1; the others at 1 skip their decrement and retry next cycle.
  // NOTE: every always_comb output gets a default first so no latch is built.
  always_comb begin
    w_one  = '0;
    w_load = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_one[r]  = (w_count[r] == LAT_W'(1));
      w_load[r] = w_issue && (hif.wa3_e == REG_W'(r));
    end
  end

  assign w_win       = w_one & (~w_one + NREGS'(1));
  assign w_dec       = w_busy & ~(w_one & ~w_win);
  assign w_lwb_valid = |w_one;

  always_comb begin
    w_lwb_reg = '0;
    for (int r = 0; r < NREGS; r++)
      if (w_win[r]) w_lwb_reg = REG_W'(r);
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_sb
    sb_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load[r]),
      .i_load_val (w_lat),
      .i_dec      (w_dec[r]),
      .o_count    (w_count[r]),
      .o_busy     (w_busy[r])
    );
  end

  // Outstanding long ops; issue and retire in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!reset) r_inflight <= '0;
    else begin
      case ({w_issue, w_lwb_valid})
        2'b10:   r_inflight <= r_inflight + IF_W'(1);
        2'b01:   r_inflight <= r_inflight - IF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // M forwarding is suppressed while the M destination is still owned by a
  // long op, since ALUOutM does not hold that register's final value.
  always_comb begin
    w_forward = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (hif.regwrite_m && hif.wa3_m == hif.ra_e[i*REG_W +: REG_W] &&
          !w_busy[hif.wa3_m])
        w_forward[2*i +: 2] = FWD_M;
      else if (hif.regwrite_w && hif.wa3_w == hif.ra_e[i*REG_W +: REG_W])
        w_forward[2*i +: 2] = FWD_W;
      else
        w_forward[2*i +: 2] = FWD_RF;
    end
  end

  always_comb begin
    w_ldstall = 1'b0;
    w_sbstall = (hif.regwrite_d && w_busy[hif.wa3_d]) ||
                (hif.long_d && r_inflight == IF_W'(MAX_INFLIGHT));
    for (int i = 0; i < NSRC; i++) begin
      if (hif.use_d[i] && hif.ra_d[i*REG_W +: REG_W] == hif.wa3_e)
        w_ldstall = hif.regwrite_e & hif.memtoreg_e & ~hif.long_e;
      if (hif.use_d[i] && w_busy[hif.ra_d[i*REG_W +: REG_W]])
        w_sbstall = 1'b1;
    end
  end

  assign hif.forward_e = w_forward;
  assign hif.stall_d   = w_ldstall | w_sbstall;
  assign hif.stall_f   = w_ldstall | w_sbstall | hif.pc_pend;
  assign hif.flush_e   = w_ldstall | w_sbstall | hif.branch_taken_e;
  assign hif.flush_d   = hif.pc_pend | hif.pcsrc_w | hif.branch_taken_e;
  assign hif.busy      = w_busy;
  assign hif.lwb_valid = w_lwb_valid;
  assign hif.lwb_reg   = w_lwb_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Long-unit writebacks are predicted
// into a queue at issue time and matched against lwb_valid/lwb_reg.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NREGS = 16;
  localparam int NSRC  = 3;
  localparam int LAT_W = 3;

  typedef struct {
    int rg;
    int due;
  } lwb_exp_t;

  logic     clk = 1'b0;
  logic     reset;
  int       total = 0;
  int       bad   = 0;
  int       cyc   = 0;
  lwb_exp_t exp_q[$];

  hazard_scoreboard_if #(.NREGS(NREGS), .NSRC(NSRC), .LAT_W(LAT_W)) hif ();

  hazard_scoreboard #(.NREGS(NREGS), .NSRC(NSRC), .LAT_W(LAT_W),
                      .MAX_INFLIGHT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] pack3(input int a, input int b, input int c);
    return {4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic expect_lwb(input int rg, input int due);
    lwb_exp_t e;
    e.rg  = rg;
    e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    hif.ra_d = '0; hif.use_d = '0; hif.wa3_d = '0; hif.regwrite_d = 0;
    hif.long_d = 0; hif.ra_e = '0; hif.wa3_e = '0; hif.regwrite_e = 0;
    hif.memtoreg_e = 0; hif.long_e = 0; hif.lat_e = '0; hif.wa3_m = '0;
    hif.regwrite_m = 0; hif.wa3_w = '0; hif.regwrite_w = 0; hif.pc_pend = 0;
    hif.pcsrc_w = 0; hif.branch_taken_e = 0;
  endtask

  task automatic issue(input int rg, input int lat);
    hif.regwrite_e = 1; hif.long_e = 1;
    hif.wa3_e = 4'(rg); hif.lat_e = 3'(lat);
  endtask

  // Advance one cycle, then score any long-unit writeback against the queue.
  task automatic tick();
    int hit;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].due < cyc) begin
        check("lwb_missed_due", 32'(exp_q[i].due), 32'(cyc));
        exp_q.delete(i);
      end
    if (hif.lwb_valid) begin
      hit = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (exp_q[i].due == cyc) hit = i;
      if (hit < 0) check("lwb_spurious", 32'(hif.lwb_valid), 32'(0));
      else begin
        check("lwb_reg", 32'(hif.lwb_reg), 32'(exp_q[hit].rg));
        exp_q.delete(hit);
      end
    end
  endtask

  initial begin
    int a;

    // ---- reset ----
    reset = 1'b0;
    idle();
    tick(); tick();
    check("rst_forward", 32'(hif.forward_e), 0);
    check("rst_busy", 32'(hif.busy), 0);
    check("rst_lwb", 32'(hif.lwb_valid), 0);
    check("rst_stalls", 32'({hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e}), 0);
    reset = 1'b1;
    tick();
    check("idle_outputs", 32'({hif.forward_e, hif.stall_f, hif.stall_d,
          hif.flush_d, hif.flush_e, hif.busy, hif.lwb_valid, hif.lwb_reg}), 0);

    // ---- forwarding ----
    hif.regwrite_m = 1; hif.wa3_m = 4'd3; hif.regwrite_w = 1; hif.wa3_w = 4'd3;
    hif.ra_e = pack3(3, 3, 5);
    #1 check("fwd_m_prio", 32'(hif.forward_e), 32'(6'b00_10_10));
    hif.regwrite_m = 0;
    #1 check("fwd_w_only", 32'(hif.forward_e), 32'(6'b00_01_01));
    hif.regwrite_m = 1; hif.wa3_w = 4'd5;
    #1 check("fwd_mixed", 32'(hif.forward_e), 32'(6'b01_10_10));

    // ---- load-use ----
    tick(); idle();
    hif.regwrite_e = 1; hif.memtoreg_e = 1; hif.wa3_e = 4'd4;
    hif.ra_d = pack3(4, 0, 0); hif.use_d = 3'b000;
    #1 check("ld_unused_src", 32'(hif.stall_d), 0);
    hif.use_d = 3'b001;
    #1 check("ld_stall", 32'({hif.stall_f, hif.stall_d, hif.flush_e, hif.flush_d}),
             32'(4'b1110));
    tick();
    hif.regwrite_e = 0; hif.memtoreg_e = 0; hif.wa3_e = 4'd0;
    #1 check("ld_stall_released", 32'({hif.stall_f, hif.stall_d, hif.flush_e}), 0);

    // ---- long op, latency 3, r7 ----
    tick(); idle();
    issue(7, 3); expect_lwb(7, cyc + 3);
    #1 check("long_not_yet_busy", 32'(hif.busy), 0);
    tick(); idle();
    hif.ra_d = pack3(7, 0, 0); hif.use_d = 3'b001;
    #1 check("long_busy_c1", 32'(hif.busy), 32'h0080);
    check("raw_stall_c1", 32'({hif.stall_f, hif.stall_d, hif.flush_e}), 32'(3'b111));
    tick();
    hif.use_d = 3'b000; hif.regwrite_d = 1; hif.wa3_d = 4'd7;
    #1 check("waw_stall_c2", 32'(hif.stall_d), 1);
    check("lwb_idle_c2", 32'(hif.lwb_valid), 0);
    tick();
    hif.use_d = 3'b001; hif.regwrite_d = 0;
    #1 check("lwb_c3", 32'(hif.lwb_valid), 1);
    check("raw_stall_c3", 32'(hif.stall_d), 1);
    check("busy_c3", 32'(hif.busy), 32'h0080);
    tick();
    #1 check("raw_proceed_c4", 32'(hif.stall_d), 0);
    check("busy_clear_c4", 32'(hif.busy), 0);

    // ---- in-flight limit ----
    tick(); idle();
    a = cyc;
    issue(1, 4); expect_lwb(1, a + 4);
    tick(); idle();
    issue(2, 6); expect_lwb(2, a + 7);
    hif.long_d = 1;
    #1 check("if1_no_stall", 32'(hif.stall_d), 0);
    tick(); idle(); hif.long_d = 1;
    #1 check("if2_stall_a2", 32'(hif.stall_d), 1);
    tick();
    #1 check("if2_stall_a3", 32'(hif.stall_d), 1);
    tick();
    issue(3, 2); expect_lwb(3, a + 6);
    #1 check("if_retire_a4", 32'(hif.lwb_valid), 1);
    check("if2_stall_a4", 32'(hif.stall_d), 1);
    tick(); idle(); hif.long_d = 1;
    #1 check("if_issue_retire_holds", 32'(hif.stall_d), 1);
    tick();
    #1 check("if2_stall_a6", 32'(hif.stall_d), 1);
    tick();
    #1 check("if_drop_a7", 32'(hif.stall_d), 0);
    tick(); idle();

    // ---- branch flush during scoreboard stall ----
    issue(9, 2); expect_lwb(9, cyc + 2);
    tick(); idle();
    hif.ra_d = pack3(9, 0, 0); hif.use_d = 3'b001; hif.branch_taken_e = 1;
    #1 check("br_flush", 32'({hif.flush_e, hif.flush_d, hif.stall_d}), 32'(3'b111));
    check("br_busy", 32'(hif.busy), 32'h0200);
    tick();
    #1 check("br_busy_kept", 32'(hif.busy), 32'h0200);
    check("br_lwb", 32'(hif.lwb_valid), 1);
    tick(); idle();

    // ---- PC flush / stall ----
    hif.pc_pend = 1;
    #1 check("pc_pend", 32'({hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e}),
             32'(4'b1010));
    hif.pc_pend = 0; hif.pcsrc_w = 1;
    #1 check("pcsrc_w", 32'({hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e}),
             32'(4'b0010));
    hif.pcsrc_w = 0;

    // ---- same-cycle retire collision: lowest index first ----
    tick(); idle();
    a = cyc;
    issue(5, 3);
    tick(); idle();
    issue(4, 2);
    expect_lwb(4, a + 3); expect_lwb(5, a + 4);
    tick(); idle();
    tick();
    #1 check("coll_busy_a3", 32'(hif.busy), 32'h0030);
    tick();
    #1 check("coll_busy_a4", 32'(hif.busy), 32'h0020);
    tick();
    #1 check("coll_busy_a5", 32'(hif.busy), 0);

    // ---- zero latency behaves as one ----
    issue(6, 0); expect_lwb(6, cyc + 1);
    tick(); idle();
    #1 check("lat0_lwb", 32'({hif.lwb_valid, hif.busy}), 32'h1_0040);
    tick();

    // ---- reset mid-operation ----
    issue(2, 3);
    tick(); idle();
    tick();
    reset = 1'b0;
    #1 check("rst_between_edges", 32'(hif.busy), 32'h0004);
    tick();
    check("rst_mid_busy", 32'(hif.busy), 0);
    check("rst_mid_lwb", 32'(hif.lwb_valid), 0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_no_lwb", 32'(hif.lwb_valid), 0);
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
